// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, FSM states and frame decode for the keypad scanner
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } scan_state_t;

  // Frame result: MSB clear means a single clean key with its code in the low bits.
  typedef logic [CODE_W:0] frame_res_t;
  localparam frame_res_t RES_NONE    = 5'b10000;
  localparam frame_res_t RES_INVALID = 5'b10001;

  // Reduce one 16-key snapshot to a single code, NONE, or INVALID (ghosting).
  function automatic frame_res_t decode_frame(input logic [NUM_KEYS-1:0] bits);
    frame_res_t  res;
    int unsigned hits;
    res  = RES_NONE;
    hits = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bits[i]) begin
        hits++;
        res = {1'b0, CODE_W'(i)};
      end
    end
    if (hits > 1) res = RES_INVALID;
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key event interface; key_rd exists only with KEYPAD_FIFO_EN
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
`ifdef KEYPAD_FIFO_EN
  logic              key_rd;
`endif

  modport master (
    output key_code,
    output key_valid,
    output key_held
`ifdef KEYPAD_FIFO_EN
    , input key_rd
`endif
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_held
`ifdef KEYPAD_FIFO_EN
    , output key_rd
`endif
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer; resets to all ones (idle level of pulled-up rows)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, debounce FSM and key events; KEYPAD_FIFO_EN adds an event FIFO
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE_N = 4
`ifdef KEYPAD_FIFO_EN
  , parameter int FIFO_DEPTH = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  keypad_scanner_if.master    kif
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_N + 1);

  logic [NUM_ROWS-1:0] row_sync;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [1:0]          col_idx;
  logic [NUM_KEYS-1:0] snap;
  logic [NUM_KEYS-1:0] frame_bits;
  frame_res_t          frame_res;
  logic                last_slot;
  logic                frame_end;

  scan_state_t         state;
  logic [CNT_W-1:0]    cnt;
  logic [CODE_W-1:0]   cand;
  logic                held;
  logic                ev_strobe;
  logic [CODE_W-1:0]   ev_code;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign last_slot = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = last_slot && (col_idx == 2'(NUM_COLS - 1));

  // Slot counter and column drive; col is registered so it stays glitch-free one-hot-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
    end else if (last_slot) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      col      <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Merge the current column's rows into the snapshot so frame end sees all four columns.
  always_comb begin
    frame_bits = snap;
    for (int r = 0; r < NUM_ROWS; r++) begin
      frame_bits[{col_idx, r[1:0]}] = ~row_sync[r];
    end
  end

  assign frame_res = decode_frame(frame_bits);

  // Snapshot register, refreshed at the end of every column slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (last_slot) begin
      snap <= frame_bits;
    end
  end

  // Debounce FSM with registered event strobe, code and held flag; moves only at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      held      <= 1'b0;
      ev_strobe <= 1'b0;
      ev_code   <= '0;
    end else begin
      ev_strobe <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (!frame_res[CODE_W]) begin
              cand <= frame_res[CODE_W-1:0];
              if (DEBOUNCE_N <= 1) begin
                state     <= PRESSED;
                ev_strobe <= 1'b1;
                ev_code   <= frame_res[CODE_W-1:0];
                held      <= 1'b1;
              end else begin
                state <= DEB_PRESS;
                cnt   <= CNT_W'(1);
              end
            end
          end
          DEB_PRESS: begin
            if (frame_res == {1'b0, cand}) begin
              if (cnt + CNT_W'(1) >= CNT_W'(DEBOUNCE_N)) begin
                state     <= PRESSED;
                ev_strobe <= 1'b1;
                ev_code   <= cand;
                held      <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (frame_res[CODE_W]) begin
              if (DEBOUNCE_N <= 1) begin
                state <= IDLE;
                held  <= 1'b0;
              end else begin
                state <= DEB_REL;
                cnt   <= CNT_W'(1);
              end
            end
          end
          DEB_REL: begin
            if (frame_res[CODE_W]) begin
              if (cnt + CNT_W'(1) >= CNT_W'(DEBOUNCE_N)) begin
                state <= IDLE;
                held  <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign kif.key_held = held;

`ifdef KEYPAD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = kif.key_rd && !empty;
  // A pop frees the slot the push lands in, so push+pop when full keeps both codes.
  assign push  = ev_strobe && (!full || pop);

  // Event FIFO: new codes are dropped when full, the oldest entries are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= ev_code;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign kif.key_code  = mem[rd_ptr[AW-1:0]];
  assign kif.key_valid = !empty;
`else
  assign kif.key_code  = ev_code;
  assign kif.key_valid = ev_strobe;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner; honours KEYPAD_FIFO_EN
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int mon_exp;
  logic mon_fire;

  localparam logic [15:0] GHOST = 16'h3000;

  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV   (4),
    .DEBOUNCE_N (3)
`ifdef KEYPAD_FIFO_EN
    , .FIFO_DEPTH (4)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .row (row),
    .col (col),
    .kif (kif)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

`ifdef KEYPAD_FIFO_EN
  assign mon_fire = kif.key_valid && kif.key_rd;
`else
  assign mon_fire = kif.key_valid;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every presented event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && mon_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0d required=none", kif.key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event_code", int'(kif.key_code), mon_exp);
`ifndef KEYPAD_FIFO_EN
        check("event_held", int'(kif.key_held), 1);
`endif
      end
    end
  end

  // Return at the first negedge of the next frame (just after a frame-end edge).
  task automatic next_frame();
    int n;
    n = 0;
    while (col != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=%0d required=<100", n);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat [4];
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    rst  = 1'b1;
    keys = '0;
`ifdef KEYPAD_FIFO_EN
    kif.key_rd = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("reset_col", int'(col), 14);
    check("reset_code", int'(kif.key_code), 0);
    check("reset_valid", int'(kif.key_valid), 0);
    check("reset_held", int'(kif.key_held), 0);

    rst = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j % 4 == 0) check("col_scan", int'(col), int'(pat[(j/4)%4]));
      @(negedge clk);
    end

    // Single press of row2/col1 held five frames.
    next_frame();
    keys = 16'h1 << 6;
    exp_q.push_back(6);
    frames(5);
    keys = '0;
    frames(2);
    check("held_during_release", int'(kif.key_held), 1);
    frames(1);
    check("released", int'(kif.key_held), 0);
    check("press_pending", exp_q.size(), 0);

    // Bouncing press, then a one-frame release glitch.
    keys = 16'h1 << 9; frames(1);
    keys = '0;         frames(1);
    keys = 16'h1 << 9; frames(1);
    keys = '0;         frames(1);
    keys = 16'h1 << 9;
    exp_q.push_back(9);
    frames(2);
    check("bounce_not_early", exp_q.size(), 1);
    check("bounce_not_held", int'(kif.key_held), 0);
    frames(1);
    check("bounce_held", int'(kif.key_held), 1);
    frames(1);
    keys = '0;         frames(1);
    keys = 16'h1 << 9; frames(1);
    check("glitch_held", int'(kif.key_held), 1);
    frames(1);
    keys = '0;
    frames(3);
    check("bounce_released", int'(kif.key_held), 0);
    check("bounce_pending", exp_q.size(), 0);

    // Ghosting on column 3, then ghosting acting as release.
    keys = GHOST;
    frames(4);
    check("ghost_no_press", int'(kif.key_held), 0);
    keys = 16'h1 << 3;
    exp_q.push_back(3);
    frames(4);
    check("key3_held", int'(kif.key_held), 1);
    keys = GHOST;
    frames(2);
    check("ghost_rel_partial", int'(kif.key_held), 1);
    frames(1);
    check("ghost_released", int'(kif.key_held), 0);
`ifndef KEYPAD_FIFO_EN
    check("last_code", int'(kif.key_code), 3);
`endif
    keys = '0;
    frames(1);

    // Reset in the middle of press debouncing.
    keys = 16'h1 << 5;
    frames(2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_col", int'(col), 14);
    check("midrst_code", int'(kif.key_code), 0);
    check("midrst_valid", int'(kif.key_valid), 0);
    check("midrst_held", int'(kif.key_held), 0);
    keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frames(5);
    check("midrst_no_event", exp_q.size(), 0);

`ifdef KEYPAD_FIFO_EN
    // Fill the FIFO with codes 1..5; code 5 must be dropped.
    kif.key_rd = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      keys = 16'h1 << k;
      if (k <= 4) exp_q.push_back(k);
      frames(4);
      keys = '0;
      frames(4);
    end
    check("fifo_valid", int'(kif.key_valid), 1);
    check("fifo_head", int'(kif.key_code), 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 kif.key_rd = 1'b1;
      @(posedge clk); #1 kif.key_rd = 1'b0;
    end
    @(negedge clk);
    check("fifo_drained", int'(kif.key_valid), 0);
`endif

    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
